// File: rtl/context_store.sv
// JPEG-LS context parameter store: A/B/C/N/Nn for 365 regular + 2 run-interruption
// contexts, with a post-reset init sweep and write-first read forwarding.
module context_store #(
  parameter int unsigned A_length   = 14,
  parameter int unsigned B_length   = 8,
  parameter int unsigned C_length   = 8,
  parameter int unsigned N_length   = 7,
  parameter int unsigned Nn_length  = 7,
  parameter int unsigned IDX_length = 9,
  parameter int unsigned CTX_COUNT  = 367,
  parameter int unsigned A_INIT     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_valid,
  input  logic [IDX_length-1:0] rd_idx,
  output logic                  rd_ready,
  output logic                  init_done,
  output logic                  ctx_valid,
  output logic [A_length-1:0]   A_out,
  output logic [B_length-1:0]   B_out,
  output logic [C_length-1:0]   C_out,
  output logic [N_length-1:0]   N_out,
  output logic [Nn_length-1:0]  Nn_out,
  output logic                  idx_err,
  input  logic                  wr_valid,
  input  logic [IDX_length-1:0] wr_idx,
  input  logic [A_length-1:0]   A_in,
  input  logic [B_length-1:0]   B_in,
  input  logic [C_length-1:0]   C_in,
  input  logic [N_length-1:0]   N_in,
  input  logic [Nn_length-1:0]  Nn_in
);

  localparam int unsigned ENTRY_W = A_length + B_length + C_length + N_length + Nn_length;
  localparam logic [ENTRY_W-1:0] INIT_ENTRY = {A_length'(A_INIT), B_length'(0), C_length'(0),
                                               N_length'(1), Nn_length'(0)};
  localparam logic [IDX_length-1:0] LAST_IDX = IDX_length'(CTX_COUNT - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state, state_nxt;
  logic [IDX_length-1:0]   init_idx, init_idx_nxt;
  logic [ENTRY_W-1:0]      mem [CTX_COUNT];
  logic [ENTRY_W-1:0]      ctx_data;

  logic                    rd_in_range_c, wr_in_range_c;
  logic                    rd_accept_c, wr_accept_c;
  logic                    mem_we_c;
  logic [IDX_length-1:0]   mem_waddr_c;
  logic [ENTRY_W-1:0]      mem_wdata_c, wr_entry_c, rd_entry_c;

  assign wr_entry_c    = {A_in, B_in, C_in, N_in, Nn_in};
  assign rd_in_range_c = 32'(rd_idx) < CTX_COUNT;
  assign wr_in_range_c = 32'(wr_idx) < CTX_COUNT;

  // State register and sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
    end
  end

  // Next-state, request acceptance and storage write port selection
  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    rd_accept_c  = 1'b0;
    wr_accept_c  = 1'b0;
    mem_we_c     = 1'b0;
    mem_waddr_c  = wr_idx;
    mem_wdata_c  = wr_entry_c;
    case (state)
      S_INIT: begin
        mem_we_c     = 1'b1;
        mem_waddr_c  = init_idx;
        mem_wdata_c  = INIT_ENTRY;
        init_idx_nxt = init_idx + IDX_length'(1);
        if (init_idx == LAST_IDX) begin
          state_nxt    = S_RUN;
          init_idx_nxt = '0;
        end
      end
      S_RUN: begin
        rd_accept_c = rd_valid;
        wr_accept_c = wr_valid;
        mem_we_c    = wr_valid && wr_in_range_c;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  // Write-first: a same-cycle write to the read index bypasses storage
  always_comb begin
    rd_entry_c = '0;
    if (rd_in_range_c) begin
      if (wr_accept_c && wr_in_range_c && (wr_idx == rd_idx)) rd_entry_c = wr_entry_c;
      else                                                    rd_entry_c = mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_valid <= 1'b0;
      ctx_data  <= '0;
      idx_err   <= 1'b0;
    end else begin
      ctx_valid <= rd_accept_c;
      idx_err   <= (rd_accept_c && !rd_in_range_c) || (wr_accept_c && !wr_in_range_c);
      if (rd_accept_c) ctx_data <= rd_entry_c;
    end
  end

  assign {A_out, B_out, C_out, N_out, Nn_out} = ctx_data;
  assign rd_ready  = (state == S_RUN);
  assign init_done = (state == S_RUN);

endmodule

// File: doc/context_store.md
# context_store

Context-parameter store for the JPEG-LS regular and run-interruption coding paths. Holds A, B, C, N and Nn for all 365 regular contexts plus the 2 run-interruption contexts (indices 365 and 366). Sits directly upstream of the bias-cancellation stage:
- supplies the current context values one cycle after a read request;
- accepts the updated values back the following cycle and writes them to storage.

Sequential behaviour: a post-reset initialisation sweep and write-first read forwarding.

## Interface
Parameters:
- A_length, 14, width of A
- B_length, 8, width of B (two's complement)
- C_length, 8, width of C (two's complement)
- N_length, 7, width of N
- Nn_length, 7, width of Nn
- IDX_length, 9, context index width
- CTX_COUNT, 367, number of stored contexts
- A_INIT, 4, initial A value (8-bit images: max(2,(255+32)>>6)=4)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_valid  in  1  read request
- rd_idx  in  IDX_length  context index to read
- rd_ready  out  1  store accepts reads (high only after init sweep)
- init_done  out  1  initialisation sweep complete
- ctx_valid  out  1  A_out..Nn_out hold data for the read accepted last cycle
- A_out  out  A_length  stored A
- B_out  out  B_length  stored B
- C_out  out  C_length  stored C
- N_out  out  N_length  stored N
- Nn_out  out  Nn_length  stored Nn
- idx_err  out  1  last accepted read or write had index ≥ CTX_COUNT
- wr_valid  in  1  write-back strobe
- wr_idx  in  IDX_length  context index to write
- A_in, B_in, C_in, N_in, Nn_in  in  matching widths  updated values from bias cancellation

## Operation
Storage:
- CTX_COUNT entries of A|B|C|N|Nn.
- Implemented as a synchronous-read register array or inferred RAM, with one read port and one write port.

States:
- **INIT**
  - Entered on rst.
  - Counter init_idx counts 0..CTX_COUNT-1 and writes A=A_INIT, B=0, C=0, N=1, Nn=0 to entry init_idx, one entry per cycle.
  - rd_valid and wr_valid are ignored.
  - After the write to entry CTX_COUNT-1, go to RUN.
- **RUN**
  - rd_ready=1, init_done=1.

Read, when rd_valid && rd_ready:
- The selected entry is registered into A_out..Nn_out and ctx_valid=1 on the next cycle.
- With no read, ctx_valid=0 and the data outputs hold their last value.

Write, when wr_valid in RUN:
- The entry at wr_idx is overwritten at the clock edge.

Forwarding (write-first):
- If a read and a write are accepted in the same cycle with rd_idx==wr_idx, the outputs next cycle show A_in..Nn_in, not the old stored value.
- This supports back-to-back pixels sharing a context with bias cancellation in the loop.

Out-of-range index (≥ CTX_COUNT):
- A read drives all data outputs 0 with ctx_valid=1 and idx_err=1 for one cycle.
- A write is discarded and sets idx_err=1 for one cycle.
- idx_err is otherwise 0.

No arithmetic is performed in this block. Values are stored and returned bit-exact, and signed fields are not interpreted.

## Timing
- Reset values (cycle after rst sampled high): ctx_valid=0, all data outputs 0, rd_ready=0, init_done=0, idx_err=0, init_idx=0.
- Init sweep:
  - takes exactly CTX_COUNT cycles (367) after rst deasserts;
  - rd_ready and init_done rise together on cycle 367 counted from the first cycle with rst low.
- Read latency is 1 cycle, fully pipelined, one read per cycle sustained.
- A write is visible to a read issued in the same cycle via forwarding, and to any later read.
- rst asserted mid-RUN or mid-INIT:
  - aborts everything and restarts the sweep from 0;
  - any in-flight read is dropped (ctx_valid=0);
  - all contents are re-initialised.
- Simultaneous rst and rd_valid/wr_valid: rst wins.

## Test plan
- **Reset/init:** pulse rst 1 cycle → rd_ready=0 for 367 cycles, then 1. Read idx 0, 200, 366 → A=4, B=0, C=0, N=1, Nn=0, ctx_valid one cycle after each request.
- **Write then read:** write idx 17 with A=100, B=-5 (8'hFB), C=3, N=9, Nn=2. Read idx 17 two cycles later → exact values returned; idx 16 and idx 18 still initial.
- **Same-cycle forwarding:** in one cycle, read idx 42 and write idx 42 with A=55, N=12 → next-cycle A_out=55, N_out=12. Then write idx 42 and read idx 43 in one cycle → idx 43 returns initial values.
- **Out-of-range:** read idx 400 → outputs 0, ctx_valid=1, idx_err=1. Write idx 367 then read idx 0 → idx 0 is unchanged.
- **Requests during init:** rd_valid and wr_valid toggling during the sweep → no ctx_valid pulses; after init_done, all entries hold initial values.
- **Reset mid-run:** write idx 5 with A=999, then assert rst while a read is in flight → ctx_valid=0. After a new 367-cycle sweep, idx 5 reads A=4.
